// File: rtl/vc_credit_link.sv
// vc_credit_link: pipelined point-to-point flit link with per-VC credit counters and a flush FSM.
// Define VC_CREDIT_LINK_PERF_EN to build the perf_flits/perf_stalls counters; otherwise they read 0.
module vc_credit_link #(
    parameter int FLIT_W      = 32,
    parameter int NUM_VCS     = 2,
    parameter int PIPE_STAGES = 2,
    parameter int BUFFER_SIZE = 8,
    localparam int VW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int CW = $clog2(BUFFER_SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLIT_W-1:0]  tx_flit,
    input  logic [VW-1:0]      tx_vc,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [FLIT_W-1:0]  rx_flit,
    output logic [VW-1:0]      rx_vc,
    output logic               rx_valid,
    input  logic [NUM_VCS-1:0] credit_return,
    output logic [NUM_VCS-1:0] credit_avail,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               credit_err,
    output logic [31:0]        perf_flits,
    output logic [31:0]        perf_stalls
);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt [NUM_VCS];
    logic [NUM_VCS-1:0] ret;
    logic [NUM_VCS-1:0] acc_vc;
    logic               accept;
    logic               vc_ok;
    logic               fwd_busy;
    logic               crd_busy;
    logic               all_full;

    assign vc_ok    = (32'(tx_vc) < 32'(NUM_VCS));
    assign tx_ready = (state == RUN) && vc_ok && (cnt[tx_vc] != '0);
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        acc_vc   = '0;
        all_full = 1'b1;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            acc_vc[v]       = accept && (tx_vc == VW'(v));
            credit_avail[v] = (cnt[v] != '0);
            if (cnt[v] != CW'(BUFFER_SIZE))
                all_full = 1'b0;
        end
    end

    // Simultaneous accept and return on one VC cancel; a return onto a full counter is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VCS; v++)
                cnt[v] <= CW'(BUFFER_SIZE);
            credit_err <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                if (acc_vc[v] && !ret[v]) begin
                    cnt[v] <= cnt[v] - CW'(1);
                end else if (ret[v] && !acc_vc[v]) begin
                    if (cnt[v] == CW'(BUFFER_SIZE))
                        credit_err <= 1'b1;
                    else
                        cnt[v] <= cnt[v] + CW'(1);
                end
            end
        end
    end

    generate
        if (PIPE_STAGES == 0) begin : g_nopipe
            assign rx_flit  = tx_flit;
            assign rx_vc    = tx_vc;
            assign rx_valid = accept;
            assign ret      = credit_return;
            assign fwd_busy = 1'b0;
            assign crd_busy = 1'b0;
        end else begin : g_pipe
            logic [FLIT_W-1:0]      flit_q [PIPE_STAGES];
            logic [VW-1:0]          vc_q   [PIPE_STAGES];
            logic [PIPE_STAGES-1:0] val_q;
            logic [NUM_VCS-1:0]     crd_q  [PIPE_STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    val_q <= '0;
                    for (int unsigned i = 0; i < PIPE_STAGES; i++)
                        crd_q[i] <= '0;
                end else begin
                    val_q[0] <= accept;
                    crd_q[0] <= credit_return;
                    for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                        val_q[i] <= val_q[i-1];
                        crd_q[i] <= crd_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                flit_q[0] <= tx_flit;
                vc_q[0]   <= tx_vc;
                for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                    flit_q[i] <= flit_q[i-1];
                    vc_q[i]   <= vc_q[i-1];
                end
            end

            always_comb begin
                crd_busy = 1'b0;
                for (int unsigned i = 0; i < PIPE_STAGES; i++)
                    if (crd_q[i] != '0)
                        crd_busy = 1'b1;
            end

            assign rx_flit  = flit_q[PIPE_STAGES-1];
            assign rx_vc    = vc_q[PIPE_STAGES-1];
            assign rx_valid = val_q[PIPE_STAGES-1];
            assign ret      = crd_q[PIPE_STAGES-1];
            assign fwd_busy = |val_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (flush_req) state_nx = DRAIN;
            DRAIN:   if (!fwd_busy && !crd_busy && all_full) state_nx = DONE;
            DONE:    if (!flush_req) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    assign flush_done = (state == DONE);

`ifdef VC_CREDIT_LINK_PERF_EN
    logic [31:0] flits_q;
    logic [31:0] stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flits_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (accept)
                flits_q <= flits_q + 32'd1;
            if (tx_valid && !tx_ready)
                stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_flits  = flits_q;
    assign perf_stalls = stalls_q;
`else
    assign perf_flits  = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_vc_credit_link.sv
// Bench for vc_credit_link: directed steps plus random traffic against a cycle-scheduled reference model.
module tb_vc_credit_link;
    localparam int FW = 32;
    localparam int NV = 2;
    localparam int P  = 2;
    localparam int B  = 8;
    localparam int VW = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] tx_flit;
    logic [VW-1:0] tx_vc;
    logic          tx_valid;
    logic          tx_ready;
    logic [FW-1:0] rx_flit;
    logic [VW-1:0] rx_vc;
    logic          rx_valid;
    logic [NV-1:0] credit_return;
    logic [NV-1:0] credit_avail;
    logic          flush_req;
    logic          flush_done;
    logic          credit_err;
    logic [31:0]   perf_flits;
    logic [31:0]   perf_stalls;

    always #5 clk = ~clk;

    vc_credit_link #(.FLIT_W(FW), .NUM_VCS(NV), .PIPE_STAGES(P), .BUFFER_SIZE(B)) dut (
        .clk(clk), .rst(rst), .tx_flit(tx_flit), .tx_vc(tx_vc), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_flit(rx_flit), .rx_vc(rx_vc), .rx_valid(rx_valid),
        .credit_return(credit_return), .credit_avail(credit_avail), .flush_req(flush_req),
        .flush_done(flush_done), .credit_err(credit_err), .perf_flits(perf_flits),
        .perf_stalls(perf_stalls)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: credits as plain integers, deliveries and credit arrivals keyed by absolute cycle.
    int            mcnt [NV];
    int            owed [NV];
    int            mstate;          // 0 running, 1 draining, 2 drained
    bit            merr;
    longint        n = 0;
    logic [FW-1:0] dflit [longint];
    logic [VW-1:0] dvc   [longint];
    logic [NV-1:0] rets  [longint];
    int unsigned   pflits;
    int unsigned   pstalls;
    bit            ok;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void mreset();
        for (int v = 0; v < NV; v++) begin
            mcnt[v] = B;
            owed[v] = 0;
        end
        mstate  = 0;
        merr    = 1'b0;
        pflits  = 0;
        pstalls = 0;
        dflit.delete();
        dvc.delete();
        rets.delete();
    endfunction

    task automatic do_reset();
        tx_valid      = 1'b0;
        tx_vc         = '0;
        tx_flit       = '0;
        credit_return = '0;
        flush_req     = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mreset();
    endtask

    task automatic cyc(input bit v, input logic [VW-1:0] vc, input logic [FW-1:0] f,
                       input logic [NV-1:0] r, input bit fl);
        bit            ready, acc, drained, a;
        logic [NV-1:0] arr, avail;
        tx_valid      = v;
        tx_vc         = vc;
        tx_flit       = f;
        credit_return = r;
        flush_req     = fl;
        @(negedge clk);
        ready = (mstate == 0) && (mcnt[vc] > 0);
        acc   = v && ready;
        if (acc) begin
            dflit[n+P] = f;
            dvc[n+P]   = vc;
        end
        chk("tx_ready", tx_ready, ready);
        chk("rx_valid", rx_valid, dflit.exists(n));
        if (dflit.exists(n)) begin
            chk("rx_flit", rx_flit, dflit[n]);
            chk("rx_vc", rx_vc, dvc[n]);
            owed[dvc[n]]++;
        end
        for (int i = 0; i < NV; i++) avail[i] = (mcnt[i] > 0);
        chk("credit_avail", credit_avail, avail);
        chk("credit_err", credit_err, merr);
        chk("flush_done", flush_done, mstate == 2);
`ifdef VC_CREDIT_LINK_PERF_EN
        chk("perf_flits", perf_flits, pflits);
        chk("perf_stalls", perf_stalls, pstalls);
`else
        chk("perf_flits", perf_flits, 0);
        chk("perf_stalls", perf_stalls, 0);
`endif
        drained = 1'b1;
        for (longint k = n; k < n + P; k++)
            if (dflit.exists(k) || rets.exists(k)) drained = 1'b0;
        for (int i = 0; i < NV; i++)
            if (mcnt[i] != B) drained = 1'b0;
        if (r != '0) rets[n+P] = r;
        arr = rets.exists(n) ? rets[n] : '0;
        for (int i = 0; i < NV; i++)
            if (r[i] && owed[i] > 0) owed[i]--;
        for (int i = 0; i < NV; i++) begin
            a = acc && (int'(vc) == i);
            if (a && !arr[i]) mcnt[i]--;
            else if (arr[i] && !a) begin
                if (mcnt[i] == B) merr = 1'b1;
                else mcnt[i]++;
            end
        end
        if (acc) pflits++;
        if (v && !ready) pstalls++;
        case (mstate)
            0: if (fl) mstate = 1;
            1: if (drained) mstate = 2;
            default: if (!fl) mstate = 0;
        endcase
        if (dflit.exists(n)) begin
            dflit.delete(n);
            dvc.delete(n);
        end
        if (rets.exists(n)) rets.delete(n);
        n++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, '0, '0, '0, 1'b0);
    endtask

    // Downstream hands back every owed credit until the link is quiet (and drained, if flushing).
    task automatic settle(input bit fl, input int budget, output bit met);
        logic [NV-1:0] r;
        met = 1'b0;
        for (int c = 0; c < budget; c++) begin
            met = (dflit.size() == 0) && (rets.size() == 0) && (!fl || mstate == 2);
            for (int i = 0; i < NV; i++)
                if (owed[i] != 0 || mcnt[i] != B) met = 1'b0;
            if (met) break;
            for (int i = 0; i < NV; i++) r[i] = (owed[i] > 0);
            cyc(1'b0, '0, '0, r, fl);
        end
        chk("settle_done", met, 1'b1);
    endtask

    initial begin
        logic [NV-1:0] r;

        // Reset state
        do_reset();
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_credit_avail", credit_avail, 2'b11);
        chk("rst_credit_err", credit_err, 1'b0);
        chk("rst_flush_done", flush_done, 1'b0);

        // Single flit, PIPE_STAGES cycles of latency
        cyc(1'b1, 1'b0, 32'hA5A5_0001, '0, 1'b0);
        idle(1);
        chk("first_rx_valid", rx_valid, 1'b1);
        chk("first_rx_flit", rx_flit, 32'hA5A5_0001);
        chk("first_rx_vc", rx_vc, 1'b0);

        // Exhaust VC1 credits
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 32'h1000 + i, '0, 1'b0);
        tx_valid = 1'b1;
        tx_vc    = 1'b1;
        #1;
        chk("vc1_blocked", tx_ready, 1'b0);
        chk("vc1_avail", credit_avail, 2'b01);
        cyc(1'b1, 1'b1, 32'hDEAD_0001, '0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0000_0C00, '0, 1'b0);

        // Accept on VC0 in the cycle its delayed return arrives
        cyc(1'b0, '0, '0, 2'b01, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 32'h0000_0C01, '0, 1'b0);

        // Spurious return on a full counter
        settle(1'b0, 60, ok);
        cyc(1'b0, '0, '0, 2'b10, 1'b0);
        idle(3);
        chk("err_set", credit_err, 1'b1);
        idle(2);
        chk("err_sticky", credit_err, 1'b1);

        // Reset in the middle of a transfer
        cyc(1'b1, 1'b0, 32'h5555_0000, '0, 1'b0);
        cyc(1'b1, 1'b1, 32'h5555_0001, '0, 1'b0);
        do_reset();
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_err", credit_err, 1'b0);
        idle(3);

        // Flush with flits in flight
        cyc(1'b1, 1'b0, 32'hF000_0000, '0, 1'b0);
        cyc(1'b1, 1'b1, 32'hF000_0001, '0, 1'b0);
        cyc(1'b1, 1'b0, 32'hF000_0002, '0, 1'b1);
        tx_valid = 1'b1;
        tx_vc    = 1'b0;
        #1;
        chk("flush_blocks", tx_ready, 1'b0);
        settle(1'b1, 60, ok);
        chk("flush_done_set", flush_done, 1'b1);
        cyc(1'b0, '0, '0, '0, 1'b0);
        chk("flush_release_ready", tx_ready, 1'b1);
        chk("flush_release_done", flush_done, 1'b0);

        // Performance counters: 5 accepts then 4 stalled cycles while draining
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'hB000 + i, '0, 1'b0);
        cyc(1'b1, 1'b1, 32'hB004, '0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'hBBBB, '0, 1'b1);
`ifdef VC_CREDIT_LINK_PERF_EN
        chk("perf_flits_5", perf_flits, 32'd5);
        chk("perf_stalls_4", perf_stalls, 32'd4);
`else
        chk("perf_flits_off", perf_flits, 32'd0);
        chk("perf_stalls_off", perf_stalls, 32'd0);
`endif
        settle(1'b1, 60, ok);
        cyc(1'b0, '0, '0, '0, 1'b0);

        // Random traffic with a well-behaved downstream
        for (int i = 0; i < 400; i++) begin
            for (int v = 0; v < NV; v++) r[v] = (owed[v] > 0) && ($urandom_range(0, 2) == 0);
            cyc(1'($urandom_range(0, 1)), VW'($urandom_range(0, NV - 1)), FW'($urandom), r, 1'b0);
        end
        settle(1'b0, 100, ok);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
